// File: rtl/sw_debouncer_pkg.sv
// Shared types and helpers for the switch debouncer front-end.
// Other button/switch front-ends use the same window derivation.
package sw_debouncer_pkg;

    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_RISING  = 2'd1,
        ST_HIGH    = 2'd2,
        ST_FALLING = 2'd3
    } db_state_t;

    // Number of consecutive confirming samples needed before the level changes.
    function automatic int stable_cycles(input int clk_hz, input int debounce_us);
        return (clk_hz / 1_000_000) * debounce_us;
    endfunction

    // Counter width wide enough to hold STABLE_CYCLES.
    function automatic int cnt_width(input int stable);
        return $clog2(stable + 1);
    endfunction

endpackage

// File: rtl/sw_debouncer_channel.sv
// One debounced switch channel: synchroniser, confirmation FSM, window
// counter and registered level / pulse / toggle outputs.
//
//  state      | meaning
//  -----------+----------------------------------------------------------
//  ST_LOW     | debounced level is 0, input agrees
//  ST_RISING  | level is 0, input has read 1 for cnt consecutive samples
//  ST_HIGH    | debounced level is 1, input agrees
//  ST_FALLING | level is 1, input has read 0 for cnt consecutive samples
module sw_debouncer_channel
    import sw_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_in,
    output logic sw_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic sw_toggle
);

    localparam int               CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser; only s2 is allowed to reach the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sw_in;
            s2 <= s1;
        end
    end

    // Confirmation FSM: any opposite sample inside a window restarts it from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_LOW;
            cnt        <= '0;
            sw_out     <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            sw_toggle  <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            case (state)
                ST_LOW: begin
                    if (s2) begin
                        state <= ST_RISING;
                        cnt   <= CNT_ONE;
                    end
                end
                ST_RISING: begin
                    if (!s2) begin
                        state <= ST_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state      <= ST_HIGH;
                        cnt        <= '0;
                        sw_out     <= 1'b1;
                        rise_pulse <= 1'b1;
                        sw_toggle  <= ~sw_toggle;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!s2) begin
                        state <= ST_FALLING;
                        cnt   <= CNT_ONE;
                    end
                end
                ST_FALLING: begin
                    if (s2) begin
                        state <= ST_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state      <= ST_LOW;
                        cnt        <= '0;
                        sw_out     <= 1'b0;
                        fall_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= ST_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sw_debouncer.sv
// Slide-switch front-end: NUM_SW fully independent debounce channels
// feeding the clock-divider SW select and mode logic.
module sw_debouncer
    import sw_debouncer_pkg::*;
#(
    parameter int NUM_SW      = 1,
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_US = 10_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_SW-1:0] sw_in,
    output logic [NUM_SW-1:0] sw_out,
    output logic [NUM_SW-1:0] rise_pulse,
    output logic [NUM_SW-1:0] fall_pulse,
    output logic [NUM_SW-1:0] sw_toggle
);

    localparam int STABLE_CYCLES = stable_cycles(CLK_HZ, DEBOUNCE_US);

    // A window shorter than two samples cannot tell a glitch from a level.
    if (STABLE_CYCLES < 2) begin : g_bad_window
        $error("sw_debouncer: STABLE_CYCLES=%0d must be >= 2", STABLE_CYCLES);
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
        sw_debouncer_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .sw_in     (sw_in[i]),
            .sw_out    (sw_out[i]),
            .rise_pulse(rise_pulse[i]),
            .fall_pulse(fall_pulse[i]),
            .sw_toggle (sw_toggle[i])
        );
    end

endmodule

// File: tb/tb_sw_debouncer.sv
// Bench for sw_debouncer: directed scenarios followed by random switching,
// with a window-based reference model feeding a per-cycle scoreboard.
module tb_sw_debouncer;

    localparam int NUM_SW      = 2;
    localparam int CLK_HZ      = 1_000_000;
    localparam int DEBOUNCE_US = 8;
    localparam int WIN         = 8;

    typedef struct packed {
        logic [1:0] lvl;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] tog;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] sw_in = 2'b11;
    logic [1:0] sw_out, rise_pulse, fall_pulse, sw_toggle;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    int   rise_seen[2] = '{0, 0};
    int   fall_seen[2] = '{0, 0};

    // reference model state: raw captures and the last WIN samples the channel has judged
    logic [1:0]     m_c1, m_c2, m_out, m_tog;
    logic [WIN-1:0] m_win[2];
    int             m_n[2];

    int         r0, r1, f0, f1;
    int         hold[2];
    logic [1:0] v;

    sw_debouncer #(
        .NUM_SW     (NUM_SW),
        .CLK_HZ     (CLK_HZ),
        .DEBOUNCE_US(DEBOUNCE_US)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_in     (sw_in),
        .sw_out    (sw_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .sw_toggle (sw_toggle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [1:0] val, input int n);
        sw_in = val;
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    // Model: a level flips once the last WIN judged samples all disagree with it.
    initial begin
        m_c1 = '0; m_c2 = '0; m_out = '0; m_tog = '0;
        m_win[0] = '0; m_win[1] = '0; m_n[0] = 0; m_n[1] = 0;
        forever begin
            exp_t       e;
            logic [1:0] seen;
            @(posedge clk);
            e = '0;
            if (!reset) begin
                m_c1 = '0; m_c2 = '0; m_out = '0; m_tog = '0;
                for (int b = 0; b < 2; b++) begin
                    m_win[b] = '0;
                    m_n[b]   = 0;
                end
            end else begin
                seen = m_c2;
                m_c2 = m_c1;
                m_c1 = sw_in;
                for (int b = 0; b < 2; b++) begin
                    m_win[b] = {m_win[b][WIN-2:0], seen[b]};
                    if (m_n[b] < WIN) m_n[b]++;
                    if (m_n[b] == WIN && m_win[b] == {WIN{~m_out[b]}}) begin
                        m_out[b] = ~m_out[b];
                        if (m_out[b]) begin
                            e.rise[b] = 1'b1;
                            m_tog[b]  = ~m_tog[b];
                        end else begin
                            e.fall[b] = 1'b1;
                        end
                    end
                end
            end
            e.lvl = m_out;
            e.tog = m_tog;
            exp_q.push_back(e);
        end
    end

    // Monitor: every cycle the outputs are a response; compare against the queue head.
    initial begin
        forever begin
            exp_t e, a;
            @(negedge clk);
            a = {sw_out, rise_pulse, fall_pulse, sw_toggle};
            for (int b = 0; b < 2; b++) begin
                rise_seen[b] += int'(rise_pulse[b]);
                fall_seen[b] += int'(fall_pulse[b]);
            end
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                if (!reset) e = '0;
                check("cycle_outputs", int'(a), int'(e));
            end
        end
    end

    initial begin
        @(posedge clk);
        #3;
        // 1: reset held with inputs high, then full debounce after release
        step(2'b11, 20);
        check("reset_hold_out", int'(sw_out), 0);
        reset = 1'b1;
        step(2'b11, 9);
        check("post_reset_not_yet", int'(sw_out), 0);
        step(2'b11, 1);
        check("post_reset_out", int'(sw_out), 3);
        check("post_reset_rise", int'(rise_pulse), 3);
        step(2'b11, 1);
        check("post_reset_rise_1cyc", int'(rise_pulse), 0);
        step(2'b00, 12);

        // 2: clean edges on bit0 (toggle was 1 from the post-reset rise)
        step(2'b01, 9);
        check("clean_rise_early", int'(sw_out[0]), 0);
        step(2'b01, 1);
        check("clean_rise_out", int'(sw_out[0]), 1);
        check("clean_rise_pulse", int'(rise_pulse[0]), 1);
        check("clean_rise_toggle", int'(sw_toggle[0]), 0);
        step(2'b00, 9);
        check("clean_fall_early", int'(sw_out[0]), 1);
        step(2'b00, 1);
        check("clean_fall_out", int'(sw_out[0]), 0);
        check("clean_fall_pulse", int'(fall_pulse[0]), 1);
        check("clean_fall_toggle", int'(sw_toggle[0]), 0);
        step(2'b00, 2);

        // 3: glitch one sample short of the window
        r0 = rise_seen[0];
        step(2'b01, 7);
        step(2'b00, 12);
        check("glitch_no_rise", rise_seen[0] - r0, 0);
        check("glitch_level", int'(sw_out[0]), 0);

        // 4: bounce then stable high
        r0 = rise_seen[0];
        repeat (3) begin
            step(2'b01, 2);
            step(2'b00, 2);
        end
        step(2'b01, 9);
        check("bounce_early", int'(sw_out[0]), 0);
        step(2'b01, 1);
        check("bounce_rise_pulse", int'(rise_pulse[0]), 1);
        step(2'b01, 4);
        check("bounce_single_rise", rise_seen[0] - r0, 1);

        // 5: reset mid-window with bit1 already high
        step(2'b00, 12);
        step(2'b10, 12);
        check("pre_reset_bit1", int'(sw_out), 2);
        step(2'b11, 7);
        reset = 1'b0;
        #1;
        check("async_reset_out", int'(sw_out), 0);
        check("async_reset_toggle", int'(sw_toggle), 0);
        step(2'b11, 3);
        r0 = rise_seen[0];
        r1 = rise_seen[1];
        reset = 1'b1;
        step(2'b11, 9);
        check("rerun_early", int'(sw_out), 0);
        step(2'b11, 1);
        check("rerun_out", int'(sw_out), 3);
        step(2'b11, 3);
        check("rerun_rise0", rise_seen[0] - r0, 1);
        check("rerun_rise1", rise_seen[1] - r1, 1);

        // 6: simultaneous rise, then a glitch on bit1 only
        step(2'b00, 12);
        step(2'b11, 9);
        step(2'b11, 1);
        check("indep_both_rise", int'(rise_pulse), 3);
        f0 = fall_seen[0];
        f1 = fall_seen[1];
        step(2'b01, 3);
        step(2'b11, 12);
        check("indep_level", int'(sw_out), 3);
        check("indep_bit1_no_fall", fall_seen[1] - f1, 0);
        check("indep_bit0_no_fall", fall_seen[0] - f0, 0);

        // random switching with one reset pulse in the middle
        hold[0] = 0;
        hold[1] = 0;
        v = sw_in;
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 2; b++) begin
                if (hold[b] == 0) begin
                    v[b]    = 1'($urandom_range(0, 1));
                    hold[b] = $urandom_range(1, 12);
                end
                hold[b]--;
            end
            if (c == 200) reset = 1'b0;
            if (c == 203) reset = 1'b1;
            step(v, 1);
        end
        step(v, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
